// File: rtl/xadc_current_monitor_pkg.sv
// Shared definitions for the XADC current monitor: scan FSM encoding, aux-channel DRP
// addresses and extraction of the 12-bit conversion result from a DRP read word.
package xadc_current_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_UPDATE = 2'd3
   } state_t;

   localparam logic [6:0] VAUX6  = 7'h16;
   localparam logic [6:0] VAUX14 = 7'h1E;

   localparam int RES_MSB = 15;
   localparam int RES_LSB = 4;
   localparam int RES_W   = RES_MSB - RES_LSB + 1;

   // XADC left-justifies its 12-bit code in the 16-bit status register
   function automatic logic [RES_W-1:0] drp_result(input logic [15:0] word);
      return word[RES_MSB:RES_LSB];
   endfunction

endpackage

// File: rtl/xadc_current_monitor_if.sv
// DRP port between the current monitor (master) and the XADC wizard instance (slave).
interface xadc_current_monitor_if;

   logic        drp_den;
   logic [6:0]  drp_daddr;
   logic        drp_drdy;
   logic [15:0] drp_do;

   modport master (output drp_den, output drp_daddr, input drp_drdy, input drp_do);
   modport slave  (input drp_den, input drp_daddr, output drp_drdy, output drp_do);

endinterface

// File: rtl/current_hyst_channel.sv
// One monitored channel: debounced hysteresis on each new sample plus a sticky trip flag.
module current_hyst_channel #(
   parameter int TRIP_HI  = 950,
   parameter int TRIP_LO  = 900,
   parameter int DEBOUNCE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        upd,
   input  logic [11:0] sample,
   input  logic        trip_clear,
   output logic        over,
   output logic        trip
);

   localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             qual;
   logic             done;
   logic             rise;

   // A qualifying sample is one that argues for leaving the current state
   always_comb begin
      qual    = over ? (sample < 12'(TRIP_LO)) : (sample >= 12'(TRIP_HI));
      cnt_inc = cnt + CNT_W'(1);
      done    = qual && (cnt_inc == CNT_W'(DEBOUNCE));
      rise    = upd && done && !over;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         over <= 1'b0;
         trip <= 1'b0;
      end else begin
         if (upd) begin
            if (!qual) begin
               cnt <= '0;
            end else if (done) begin
               cnt  <= '0;
               over <= !over;
            end else begin
               cnt <= cnt_inc;
            end
         end
         // a new rise outranks a simultaneous clear request
         if (rise) begin
            trip <= 1'b1;
         end else if (trip_clear && !over) begin
            trip <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/xadc_current_monitor.sv
// DRP master that periodically scans NUM_CH XADC aux channels and feeds each result
// through a per-channel hysteresis/debounce stage producing overcurrent and trip flags.
module xadc_current_monitor
   import xadc_current_monitor_pkg::*;
#(
   parameter int                  NUM_CH      = 2,
   parameter logic [NUM_CH*7-1:0] CH_ADDR     = {VAUX14, VAUX6},
   parameter int                  SAMPLE_DIV  = 262144,
   parameter int                  TRIP_HI     = 950,
   parameter int                  TRIP_LO     = 900,
   parameter int                  DEBOUNCE    = 4,
   parameter int                  DRP_TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   xadc_current_monitor_if.master drp,
   input  logic                   trip_clear,
   output logic [NUM_CH*12-1:0]   current_value,
   output logic                   sample_valid,
   output logic [2:0]             sample_ch,
   output logic [NUM_CH-1:0]      overcurrent,
   output logic [NUM_CH-1:0]      trip_latched,
   output logic                   reset_out,
   output logic                   drp_error
);

   localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int WAIT_W = (DRP_TIMEOUT > 1) ? $clog2(DRP_TIMEOUT + 1) : 1;

   state_t            state;
   logic [DIV_W-1:0]  div_q;
   logic [WAIT_W-1:0] wcnt;
   logic [2:0]        ch;
   logic [11:0]       sample_p0;
   logic [NUM_CH-1:0] upd_stb;
   logic              tick;
   logic              last_ch;
   logic [2:0]        ch_nxt;

   function automatic logic [6:0] addr_of(input logic [2:0] c);
      logic [6:0] a;
      a = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (c == 3'(i)) a = CH_ADDR[i*7 +: 7];
      end
      return a;
   endfunction

   always_comb begin
      tick    = (div_q == DIV_W'(SAMPLE_DIV - 1));
      last_ch = (ch == 3'(NUM_CH - 1));
      ch_nxt  = ch + 3'd1;
      upd_stb = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         upd_stb[i] = (state == ST_UPDATE) && (ch == 3'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         div_q         <= '0;
         wcnt          <= '0;
         ch            <= '0;
         drp.drp_den   <= 1'b0;
         drp.drp_daddr <= '0;
         current_value <= '0;
         sample_valid  <= 1'b0;
         sample_ch     <= '0;
         reset_out     <= 1'b0;
         drp_error     <= 1'b0;
      end else begin
         div_q        <= tick ? '0 : div_q + DIV_W'(1);
         drp.drp_den  <= 1'b0;
         sample_valid <= 1'b0;
         reset_out    <= |trip_latched;
         // a tick that arrives while a scan is still running is an overrun
         if (tick && state != ST_IDLE) drp_error <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (tick) begin
                  ch            <= '0;
                  state         <= ST_ISSUE;
                  drp.drp_den   <= 1'b1;
                  drp.drp_daddr <= addr_of(3'd0);
               end
            end
            ST_ISSUE: begin
               wcnt  <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (drp.drp_drdy) begin
                  sample_p0    <= drp_result(drp.drp_do);
                  sample_valid <= 1'b1;
                  sample_ch    <= ch;
                  state        <= ST_UPDATE;
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (ch == 3'(i)) current_value[i*12 +: 12] <= drp_result(drp.drp_do);
                  end
               end else if (wcnt == WAIT_W'(DRP_TIMEOUT - 1)) begin
                  drp_error <= 1'b1;
                  if (last_ch) begin
                     state <= ST_IDLE;
                  end else begin
                     ch            <= ch_nxt;
                     state         <= ST_ISSUE;
                     drp.drp_den   <= 1'b1;
                     drp.drp_daddr <= addr_of(ch_nxt);
                  end
               end else begin
                  wcnt <= wcnt + WAIT_W'(1);
               end
            end
            ST_UPDATE: begin
               if (last_ch) begin
                  state <= ST_IDLE;
               end else begin
                  ch            <= ch_nxt;
                  state         <= ST_ISSUE;
                  drp.drp_den   <= 1'b1;
                  drp.drp_daddr <= addr_of(ch_nxt);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Hysteresis stage: each channel sees the captured sample during its UPDATE cycle
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      current_hyst_channel #(
         .TRIP_HI  (TRIP_HI),
         .TRIP_LO  (TRIP_LO),
         .DEBOUNCE (DEBOUNCE)
      ) u_hyst (
         .clk        (clk),
         .reset      (reset),
         .upd        (upd_stb[g]),
         .sample     (sample_p0),
         .trip_clear (trip_clear),
         .over       (overcurrent[g]),
         .trip       (trip_latched[g])
      );
   end

endmodule
